// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state and forwarding-select types for the pipeline controller
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        EX_WAIT    = 2'd2,
        MEM_WAIT   = 2'd3
    } ctrl_state_t;

    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    // Youngest producer wins; register 0 is hardwired and never forwarded.
    function automatic fwd_sel_t fwd_pick(input logic mem_we, input logic [4:0] mem_dest,
                                          input logic wb_we, input logic [4:0] wb_dest,
                                          input logic [4:0] src);
        return (mem_we && mem_dest != 5'd0 && mem_dest == src) ? FWD_MEM :
               (wb_we && wb_dest != 5'd0 && wb_dest == src) ? FWD_WB : FWD_RF;
    endfunction
endpackage

// File: rtl/pipe_fwd_unit.sv
// pipe_fwd_unit: combinational EX-operand forwarding selects for both source operands
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic       mem_we,
    input  logic [4:0] mem_dest,
    input  logic       wb_we,
    input  logic [4:0] wb_dest,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel
);
    // Same priority rule applied independently to rs and rt
    always_comb begin
        fwd_a_sel = fwd_pick(mem_we, mem_dest, wb_we, wb_dest, ex_rs);
        fwd_b_sel = fwd_pick(mem_we, mem_dest, wb_we, wb_dest, ex_rt);
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer and memory-wait watchdog for the 5-stage pipeline.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_we,
    input  logic [4:0]        ex_rs,
    input  logic [4:0]        ex_rt,
    input  logic [4:0]        ex_dest,
    input  logic              mem_we,
    input  logic [4:0]        mem_dest,
    input  logic              wb_we,
    input  logic [4:0]        wb_dest,
    input  logic              ex_branch_taken,
    input  logic              ex_stall_req,
    input  logic              mem_stall_req,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_mem_bubble,
    output logic              mem_wb_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [1:0]        ctrl_state,
`ifdef PIPE_CTRL_PERF_EN
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flushes,
`endif
    output logic              err_mem_timeout
);
    localparam int WD_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

    ctrl_state_t     state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            lu, lu_stall;
    logic            unused_ex_we;

    // ex_we is informational only: load-use detection keys off ex_is_load
    assign unused_ex_we = ex_we;
    assign ctrl_state = state_q;
    assign err_mem_timeout = err_q;

    pipe_fwd_unit u_fwd (
        .mem_we   (mem_we),
        .mem_dest (mem_dest),
        .wb_we    (wb_we),
        .wb_dest  (wb_dest),
        .ex_rs    (ex_rs),
        .ex_rt    (ex_rt),
        .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel)
    );

    // Prioritised hazard resolution; a frozen stage holds ex_branch_taken so deferral is implicit
    always_comb begin
        lu = ex_valid & ex_is_load & (ex_dest != 5'd0) & id_valid
             & ((id_uses_rs & (id_rs == ex_dest)) | (id_uses_rt & (id_rt == ex_dest)))
             & (state_q != LOAD_STALL);
        lu_stall      = ~ex_branch_taken & lu;
        pc_en         = ~(reset | mem_stall_req | ex_stall_req | lu_stall);
        if_id_en      = pc_en;
        id_ex_en      = ~(reset | mem_stall_req | ex_stall_req);
        ex_mem_en     = ~(reset | mem_stall_req);
        if_id_flush   = reset | (~mem_stall_req & ~ex_stall_req & ex_branch_taken);
        id_ex_bubble  = reset | (~mem_stall_req & ~ex_stall_req & (ex_branch_taken | lu));
        ex_mem_bubble = reset | (~mem_stall_req & ex_stall_req);
        mem_wb_bubble = reset | mem_stall_req;
        state_d = mem_stall_req ? MEM_WAIT : ex_stall_req ? EX_WAIT : lu_stall ? LOAD_STALL : RUN;
    end

    // Watchdog counts consecutive MEM_WAIT cycles, saturates, and latches a sticky error
    always_comb begin
        wd_d  = (state_d == MEM_WAIT) ? ((&wd_q) ? wd_q : wd_q + 1'b1) : '0;
        err_d = err_q | ((state_d == MEM_WAIT) && (wd_d >= WD_W'(MEM_TIMEOUT)));
    end

    // Controller state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flushes      = perf_flush_q;

    // Free-running wrap-around counters of fetch-frozen cycles and redirect flushes
    always_comb begin
        perf_stall_d = perf_stall_q + {{(PERF_W-1){1'b0}}, ~pc_en};
        perf_flush_d = perf_flush_q + {{(PERF_W-1){1'b0}}, if_id_flush};
    end

    // Performance counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end
`else
    logic unused_perf_w;
    assign unused_perf_w = |PERF_W;
`endif
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the IF/ID/EX/MEM/WB stage modules and drives every pipeline-register enable, flush and bubble. It covers:
- load-use interlock
- multi-cycle EX and data-memory wait freezes
- taken-branch redirect flush
- EX-operand forwarding selects

It replaces the per-stage ad-hoc `*_stall_c` chaining with one FSM and a memory-wait watchdog.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255 — MEM_WAIT cycles before `err_mem_timeout` asserts.
- `PERF_W`, 32 — width of performance counters.

Ports (name, direction, width, meaning):
- `clock`  in  1  — sole clock, rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `id_valid`, `id_uses_rs`, `id_uses_rt`  in  1 each  — ID-stage instruction valid / reads rs / reads rt.
- `id_rs`, `id_rt`  in  5  — ID source registers.
- `ex_valid`, `ex_is_load`, `ex_we`  in  1 each  — EX-stage instruction qualifiers.
- `ex_rs`, `ex_rt`, `ex_dest`  in  5  — EX sources / destination.
- `mem_we`  in  1, `mem_dest`  in  5  — EX/MEM write-back intent.
- `wb_we`  in  1, `wb_dest`  in  5  — MEM/WB write-back intent.
- `ex_branch_taken`  in  1  — EX resolved a taken branch/jump.
- `ex_stall_req`  in  1  — multi-cycle EX op busy.
- `mem_stall_req`  in  1  — data memory not ready.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`  out  1 each  — register load enables.
- `if_id_flush`, `id_ex_bubble`, `ex_mem_bubble`, `mem_wb_bubble`  out  1 each  — insert NOP into that register.
- `fwd_a_sel`, `fwd_b_sel`  out  2  — EX operand source: 00 RF, 01 MEM/WB, 10 EX/MEM.
- `ctrl_state`  out  2  — current FSM state.
- `err_mem_timeout`  out  1  — sticky watchdog flag.
- `perf_stall_cycles`, `perf_flushes`  out  `PERF_W` — only with `PIPE_CTRL_PERF_EN`.

## Operation
States: `RUN`=0, `LOAD_STALL`=1, `EX_WAIT`=2, `MEM_WAIT`=3.

Hazard terms:
- load-use hazard `lu` = `ex_valid & ex_is_load & ex_dest!=0 & id_valid & ((id_uses_rs & id_rs==ex_dest) | (id_uses_rt & id_rt==ex_dest))`.

Event priority each cycle: `mem_stall_req` > `ex_stall_req` > `ex_branch_taken` > `lu`.

Per-event outputs; every enable not listed is 1, every flush/bubble not listed is 0:
- **mem_stall_req**: all four enables 0; `mem_wb_bubble`=1. Next state `MEM_WAIT`.
- **ex_stall_req** (no mem stall): `pc_en`, `if_id_en`, `id_ex_en` = 0; `ex_mem_bubble`=1. Next state `EX_WAIT`.
- **ex_branch_taken** (neither stall): `if_id_flush`=1 and `id_ex_bubble`=1; PC loads the redirect target. Next state `RUN`.
- **lu** only: `pc_en`=0, `if_id_en`=0, `id_ex_bubble`=1. Next state `LOAD_STALL`.
- **none**: next state `RUN`.

State rules:
- `LOAD_STALL` lasts exactly one cycle. In it, `lu` is not re-evaluated, because the load has advanced to MEM.
- `MEM_WAIT` and `EX_WAIT` persist while their request is high. On release, apply the table with the remaining inputs in the same cycle.
- A branch arriving while frozen is deferred. EX is held, so `ex_branch_taken` stays high and acts on the first unfrozen cycle.
- Forwarding (combinational, independent of state):
  - `fwd_a_sel`=10 if `mem_we & mem_dest!=0 & mem_dest==ex_rs`;
  - else 01 if `wb_we & wb_dest!=0 & wb_dest==ex_rs`;
  - else 00.
  - `fwd_b_sel` is identical using `ex_rt`.
  - Register 0 never forwards.
- Watchdog: an 8-bit-minimum saturating counter counts consecutive `MEM_WAIT` cycles and clears on leaving `MEM_WAIT`. When the count reaches `MEM_TIMEOUT`, `err_mem_timeout` sets and stays set until reset. The pipeline remains frozen; the watchdog does not force recovery.

## Timing
- FSM state and counters are registered. All enables, flushes, bubbles and forward selects are combinational (Mealy) from state and inputs, valid in the same cycle.
- Load-use costs exactly 1 bubble. A taken branch costs 2 flushed slots. Each stall-request cycle costs 1 frozen cycle.
- Reset (asynchronous, any cycle, including mid-`MEM_WAIT`):
  - state `RUN`, watchdog and perf counters 0, `err_mem_timeout` 0;
  - while `reset` is high, all enables 0 and all flush/bubble outputs 1.
- Deassertion is synchronous-safe. The first post-reset edge evaluates normally.
- Simultaneous `mem_stall_req` and `ex_branch_taken`: freeze wins and the branch is deferred.
- Simultaneous `lu` and `ex_branch_taken`: the branch wins. The dependent ID instruction is flushed, so no stall is inserted.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `perf_stall_cycles` increments every cycle with `pc_en`=0 outside reset;
  - `perf_flushes` increments each cycle `if_id_flush`=1;
  - both wrap at 2^`PERF_W`.
- Undefined: both ports, counters and logic are absent from the module.

## Structure
- Shared `pipe_ctrl_pkg` holds:
  - `ctrl_state_t` enum (`RUN`, `LOAD_STALL`, `EX_WAIT`, `MEM_WAIT`);
  - `fwd_sel_t` constants `FWD_RF`=00, `FWD_WB`=01, `FWD_MEM`=10.
- One sub-module, `pipe_fwd_unit`: purely combinational forwarding compare, instantiated once and producing both selects.

## Test plan
- Load-use: `ex_is_load`=1, `ex_dest`=5, `id_rs`=5, `id_uses_rs`=1 → one cycle with `pc_en`=0 and `id_ex_bubble`=1, state `LOAD_STALL`, then `RUN` with `pc_en`=1.
- Branch: `ex_branch_taken` pulse → `if_id_flush`=1 and `id_ex_bubble`=1 for one cycle; with PERF_EN, `perf_flushes`=1.
- Deferred branch: `mem_stall_req` held 3 cycles with `ex_branch_taken`=1 → 3 frozen cycles with `mem_wb_bubble`=1, then a flush on cycle 4.
- Forwarding: `mem_dest`=`wb_dest`=`ex_rs`=7, both write enables set → `fwd_a_sel`=10; `mem_dest`=0, `ex_rs`=0 → 00.
- Watchdog: `MEM_TIMEOUT`=4, `mem_stall_req` held 6 cycles → `err_mem_timeout` rises on the 4th `MEM_WAIT` cycle and stays high after the request drops.
- Reset mid-`MEM_WAIT`: assert `reset` asynchronously → `ctrl_state`=0 and all enables 0 immediately, with no clock edge required.
